alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked ALU with registered outputs; single-cycle ops plus an optional
// iterative shift-add multiplier built only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             ill,
  output logic [CNTW-1:0]  done_cnt
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'd10;

  logic             accept, out_free, load_alu;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   sh;

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign sh       = b[SHW-1:0];
  assign add_w    = {1'b0, a} + {1'b0, b};
  assign sub_w    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      4'd0: alu_res = a & b;
      4'd1: alu_res = a | b;
      4'd2: alu_res = a ^ b;
      4'd3: alu_res = ~a;
      4'd4: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'd5: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      4'd6: alu_res = a << sh;
      4'd7: alu_res = a >> sh;
      4'd8: alu_res = $unsigned($signed(a) >>> sh);
      4'd9: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SEQ_MUL_EN
      4'd10: alu_ill = 1'b0;  // handled by the multiplier FSM
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [SHW-1:0]   cnt;
  logic             mul_load;

  assign in_ready = reset && (state == IDLE) && out_free;
  assign load_alu = accept && (op != OP_MUL);
  assign mul_load = (state == HOLD) && out_free;

  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && op == OP_MUL) state_nxt = MUL;
      MUL:     if (cnt == LAST) state_nxt = HOLD;
      HOLD:    if (out_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One shift-add step per cycle; only the low WIDTH bits of the product are kept.
  always_ff @(posedge clk) begin
    if (accept && op == OP_MUL) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      cnt    <= '0;
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
    end
  end
`else
  assign in_ready = reset && out_free;
  assign load_alu = accept;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      {c, n, z, v, ill} <= '0;
      done_cnt  <= '0;
    end else begin
      if (load_alu) begin
        out_valid <= 1'b1;
        result    <= alu_res;
        c         <= alu_c;
        v         <= alu_v;
        ill       <= alu_ill;
        n         <= alu_res[WIDTH-1];
        z         <= (alu_res == '0);
      end
`ifdef ALU_SEQ_MUL_EN
      else if (mul_load) begin
        out_valid <= 1'b1;
        result    <= acc;
        c         <= 1'b0;
        v         <= 1'b0;
        ill       <= 1'b0;
        n         <= acc[WIDTH-1];
        z         <= (acc == '0);
      end
`endif
      else if (out_valid && out_ready) out_valid <= 1'b0;
      if (out_valid && out_ready) done_cnt <= done_cnt + CNTW'(1);
    end
  end

endmodule
